fwd_hazard_unit: RTL and testbench

//  Hazard and forwarding controller for the 5-stage pipeline. It keeps its own

---
 rtl/fwd_hazard_unit.sv | 110 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard controller for the 5-stage pipeline.
// Shadows EX/MEM/WB destination info and counts stall cycles.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } ex_rec_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
  } dst_rec_t;

  ex_rec_t  ex_q;
  dst_rec_t mem_q;
  dst_rec_t wb_q;

  logic ex_ld;
  logic ex_dep;
  logic hz;
  logic mem_wr;
  logic wb_wr;
  logic a_mem;
  logic a_wb;
  logic b_mem;
  logic b_wb;

  // Only loads still sitting in EX can't be covered by forwarding.
  assign ex_ld  = ex_q.v & ex_q.mr & (|ex_q.rd);
  assign ex_dep = (ex_q.rd == id_rs) | (ex_q.rd == id_rt);
  assign hz     = id_valid & ex_ld & ex_dep;
  assign stall  = hz & ~flush;
  assign bubble = stall | flush;

  assign mem_wr = mem_q.v & mem_q.rw & (|mem_q.rd);
  assign wb_wr  = wb_q.v & wb_q.rw & (|wb_q.rd);

  assign a_mem = mem_wr & (mem_q.rd == ex_q.rs);
  assign a_wb  = wb_wr & (wb_q.rd == ex_q.rs);
  assign b_mem = mem_wr & (mem_q.rd == ex_q.rt);
  assign b_wb  = wb_wr & (wb_q.rd == ex_q.rt);

  // Youngest producer wins: MEM before WB.
  always_comb begin
    fwd_a_sel = 2'b00;
    priority case (1'b1)
      a_mem:   fwd_a_sel = 2'b10;
      a_wb:    fwd_a_sel = 2'b01;
      default: fwd_a_sel = 2'b00;
    endcase
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    priority case (1'b1)
      b_mem:   fwd_b_sel = 2'b10;
      b_wb:    fwd_b_sel = 2'b01;
      default: fwd_b_sel = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= '{v: ex_q.v, rd: ex_q.rd, rw: ex_q.rw & ex_q.v};
      ex_q  <= '{v:  id_valid & ~stall & ~flush,
                 rs: id_rs,
                 rt: id_rt,
                 rd: id_rd,
                 rw: id_reg_write,
                 mr: id_mem_read};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && !(&stall_cnt))
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random checks of fwd_hazard_unit against an
// instruction-history model of the pipeline.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall;
  logic        bubble;
  logic [31:0] stall_cnt;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_rd(id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read),
    .flush(flush),
    .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel),
    .stall(stall),
    .bubble(bubble),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rs;
    int rt;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  // hist[0] is the instruction in EX, hist[1] one older, hist[2] oldest.
  ins_t hist[$];
  int   m_cnt;
  bit   known;
  int   checks;
  int   errors;
  bit   last_stall;
  bit   last_bubble;
  bit   m_stall;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t blank();
    ins_t b;
    b = '{v: 0, rs: 0, rt: 0, rd: 0, rw: 0, mr: 0};
    return b;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(blank());
    m_cnt = 0;
  endtask

  // Select for a source: newest older writer of that register wins.
  function automatic logic [1:0] exp_sel(input int src);
    for (int d = 1; d <= 2; d++) begin
      if (hist[d].v && hist[d].rw && hist[d].rd != 0 && hist[d].rd == src)
        return (d == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic bit exp_hz(input bit v, input int rs, input int rt);
    ins_t e;
    e = hist[0];
    return v && e.v && e.mr && e.rd != 0 && (e.rd == rs || e.rd == rt);
  endfunction

  task automatic cyc(input bit v, input int rs, input int rt, input int rd,
                     input bit rw, input bit mr, input bit fl, input bit rn);
    ins_t n;
    bit   es;
    id_valid     = v;
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    rst_n        = rn;
    @(negedge clk);
    last_stall  = stall;
    last_bubble = bubble;
    es = exp_hz(v, rs, rt) && !fl;
    m_stall = es;
    if (known) begin
      chk("stall", {31'd0, stall}, {31'd0, es});
      chk("bubble", {31'd0, bubble}, {31'd0, es || fl});
      chk("sel_a", {30'd0, fwd_a_sel}, {30'd0, exp_sel(hist[0].rs)});
      chk("sel_b", {30'd0, fwd_b_sel}, {30'd0, exp_sel(hist[0].rt)});
      chk("cnt", stall_cnt, m_cnt);
    end
    @(posedge clk);
    if (!rn) begin
      model_reset();
      known = 1;
    end else if (known) begin
      if (es && m_cnt != -1) m_cnt++;
      n = '{v: v && !es && !fl, rs: rs & 31, rt: rt & 31, rd: rd & 31,
            rw: rw, mr: mr};
      hist.push_front(n);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic expect_sel(input string tag, input logic [1:0] a,
                            input logic [1:0] b);
    chk({tag, "_a"}, {30'd0, fwd_a_sel}, {30'd0, a});
    chk({tag, "_b"}, {30'd0, fwd_b_sel}, {30'd0, b});
  endtask

  int cnt_b;
  bit cv, crw, cmr;
  int crs, crt, crd;

  initial begin
    checks = 0;
    errors = 0;
    known  = 0;
    model_reset();

    // reset with random ID inputs
    cyc(1, $urandom_range(31), $urandom_range(31), $urandom_range(31),
        1, 1, 0, 0);
    cyc(1, $urandom_range(31), $urandom_range(31), $urandom_range(31),
        1, 1, 0, 0);
    expect_sel("rst", 2'b00, 2'b00);
    chk("rst_cnt", stall_cnt, 32'd0);
    cyc(1, 1, 2, 0, 1, 0, 0, 1);
    expect_sel("first", 2'b00, 2'b00);

    // EX-to-EX forward
    cyc(1, 1, 2, 3, 1, 0, 0, 1);
    cyc(1, 3, 5, 4, 1, 0, 0, 1);
    expect_sel("exex", 2'b10, 2'b00);

    // WB forward, then MEM priority
    cyc(1, 1, 2, 3, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 7, 3, 6, 1, 0, 0, 1);
    expect_sel("wb", 2'b00, 2'b01);
    cyc(1, 1, 2, 3, 1, 0, 0, 1);
    cyc(1, 1, 2, 3, 1, 0, 0, 1);
    cyc(1, 3, 3, 8, 1, 0, 0, 1);
    expect_sel("prio", 2'b10, 2'b10);

    // load-use
    cyc(1, 1, 0, 4, 1, 1, 0, 1);
    cnt_b = m_cnt;
    cyc(1, 4, 4, 5, 1, 0, 0, 1);
    chk("lu_stall", {31'd0, last_stall}, 32'd1);
    chk("lu_bubble", {31'd0, last_bubble}, 32'd1);
    cyc(1, 4, 4, 5, 1, 0, 0, 1);
    chk("lu_stall2", {31'd0, last_stall}, 32'd0);
    expect_sel("lu", 2'b01, 2'b01);
    chk("lu_cnt", stall_cnt, cnt_b + 1);

    // zero register
    cyc(1, 1, 2, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 9, 1, 0, 0, 1);
    expect_sel("zero", 2'b00, 2'b00);
    cyc(1, 1, 0, 0, 1, 1, 0, 1);
    cyc(1, 0, 0, 9, 1, 0, 0, 1);
    chk("zero_ld", {31'd0, last_stall}, 32'd0);

    // flush beats stall, then reset mid-run
    cyc(1, 1, 0, 4, 1, 1, 0, 1);
    cnt_b = m_cnt;
    cyc(1, 4, 4, 5, 1, 0, 1, 1);
    chk("fl_stall", {31'd0, last_stall}, 32'd0);
    chk("fl_bubble", {31'd0, last_bubble}, 32'd1);
    chk("fl_cnt", stall_cnt, cnt_b);
    cyc(1, 1, 2, 3, 1, 0, 0, 1);
    cyc(1, 1, 2, 7, 1, 0, 0, 1);
    cyc(1, 3, 7, 10, 1, 0, 0, 0);
    expect_sel("mrst", 2'b00, 2'b00);
    chk("mrst_cnt", stall_cnt, 32'd0);
    cyc(1, 3, 7, 10, 1, 0, 0, 1);
    expect_sel("mrst2", 2'b00, 2'b00);

    // random traffic on a narrow register range to provoke hazards
    cv = 0; crs = 0; crt = 0; crd = 0; crw = 0; cmr = 0;
    m_stall = 0;
    for (int i = 0; i < 400; i++) begin
      bit fl;
      bit rn;
      if (!m_stall) begin
        cv  = ($urandom_range(9) < 8);
        crs = $urandom_range(3);
        crt = $urandom_range(3);
        crd = $urandom_range(3);
        crw = ($urandom_range(9) < 7);
        cmr = ($urandom_range(9) < 3);
      end
      fl = ($urandom_range(9) == 0);
      rn = ($urandom_range(49) != 0);
      cyc(cv, crs, crt, crd, crw, cmr, fl, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
